// File: rtl/rr_mux_4_1_stage.sv
// rr_mux_4_1_stage: four valid/ready requesters arbitrated round-robin into
// one registered valid/ready output. The winning index selects the data beat
// and is forwarded downstream alongside it as out_sel.
module rr_mux_4_1_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    input  logic             out_ready
);

    logic [1:0]       ptr_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [1:0]       out_sel_reg;

    logic             free;
    logic             grant_found;
    logic [1:0]       grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [WIDTH-1:0] data_arr [4];
    logic [1:0]       rot_idx  [4];
    logic [3:0]       rot_valid;

    // The output register may load when empty or being drained this cycle.
    assign free = ~out_valid_reg | out_ready;

    assign data_arr[0] = in_data0;
    assign data_arr[1] = in_data1;
    assign data_arr[2] = in_data2;
    assign data_arr[3] = in_data3;

    // Scan order starts at the priority pointer and wraps modulo 4.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_idx[gi]   = ptr_reg + 2'(gi);
            assign rot_valid[gi] = in_valid[rot_idx[gi]];
        end
    endgenerate

    // First valid requester in rotated order wins; iterate backwards so the
    // lowest scan position overrides later ones.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = rot_idx[k];
            end
        end
    end

    // Only the granted input is read, so unselected data never reaches the
    // output register.
    assign grant_data = data_arr[grant_idx];

    // Ready depends on valid/out_ready/pointer only, never on data.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ready
            assign in_ready[gi] = ~rst & free & grant_found & (grant_idx == 2'(gi));
        end
    endgenerate

    // Output register and priority pointer; everything holds under back-pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg       <= 2'd0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= 2'd0;
        end else if (free) begin
            if (grant_found) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= grant_data;
                out_sel_reg   <= grant_idx;
                ptr_reg       <= grant_idx + 2'd1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_rr_mux_4_1_stage.sv
// Directed bench for rr_mux_4_1_stage: reset, single requester, round-robin
// rotation, back-pressure, reset mid-stream and unselected-X isolation.
module tb_rr_mux_4_1_stage;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [3:0]       in_valid;
    logic [WIDTH-1:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_ready;

    int n_cmp = 0;
    int n_err = 0;

    rr_mux_4_1_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full output beat after the edge.
    task automatic chk_out(input string tag, input logic v, input logic [WIDTH-1:0] d,
                           input logic [1:0] s);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"},  32'(out_data),  32'(d));
        chk({tag, ".sel"},   32'(out_sel),   32'(s));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 4'b0000;
        in_data0  = '0;
        in_data1  = '0;
        in_data2  = '0;
        in_data3  = '0;
        out_ready = 1'b1;

        // Reset then idle
        tick();
        tick();
        chk_out("rst", 1'b0, 4'h0, 2'd0);
        chk("rst.ready", 32'(in_ready), 32'h0);
        in_valid = 4'b1111;
        #1;
        chk("rst.ready_v", 32'(in_ready), 32'h0);
        in_valid = 4'b0000;
        tick();
        rst = 1'b0;
        #1;
        chk("idle.ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("idle", 1'b0, 4'h0, 2'd0);

        // Single requester 2
        in_valid = 4'b0100;
        in_data2 = 4'hC;
        #1;
        chk("single.ready", 32'(in_ready), 32'b0100);
        tick();
        chk_out("single", 1'b1, 4'hC, 2'd2);
        // Idle cycle must not rotate priority (pointer stays 3)
        in_valid = 4'b0000;
        tick();
        chk("idle2.valid", 32'(out_valid), 32'h0);
        in_valid = 4'b1111;
        in_data0 = 4'hA;
        in_data1 = 4'hB;
        in_data2 = 4'hC;
        in_data3 = 4'hD;
        #1;
        chk("ptr3.ready", 32'(in_ready), 32'b1000);
        tick();
        chk_out("ptr3", 1'b1, 4'hD, 2'd3);

        // Round-robin from reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rr0.ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("rr0", 1'b1, 4'hA, 2'd0);
        chk("rr1.ready", 32'(in_ready), 32'b0010);
        tick();
        chk_out("rr1", 1'b1, 4'hB, 2'd1);
        chk("rr2.ready", 32'(in_ready), 32'b0100);
        tick();
        chk_out("rr2", 1'b1, 4'hC, 2'd2);
        chk("rr3.ready", 32'(in_ready), 32'b1000);
        tick();
        chk_out("rr3", 1'b1, 4'hD, 2'd3);
        tick();
        chk_out("rr4", 1'b1, 4'hA, 2'd0);
        tick();
        chk_out("rr5", 1'b1, 4'hB, 2'd1);

        // Back-pressure: hold 0xB for 3 cycles
        out_ready = 1'b0;
        #1;
        chk("bp.ready", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("bp", 1'b1, 4'hB, 2'd1);
            chk("bp.ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bprel.ready", 32'(in_ready), 32'b0100);
        tick();
        chk_out("bprel", 1'b1, 4'hC, 2'd2);

        // Advance to out_sel=1 then reset mid-stream
        tick();
        chk_out("ms_d", 1'b1, 4'hD, 2'd3);
        tick();
        chk_out("ms_a", 1'b1, 4'hA, 2'd0);
        tick();
        chk_out("ms_b", 1'b1, 4'hB, 2'd1);
        rst = 1'b1;
        tick();
        chk_out("ms_rst", 1'b0, 4'h0, 2'd0);
        rst = 1'b0;
        #1;
        chk("ms_rel.ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("ms_rel", 1'b1, 4'hA, 2'd0);

        // X isolation on unselected input 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_data0 = 4'd7;
        in_data1 = 4'd10;
        in_data2 = 4'd3;
        in_data3 = 'x;
        in_valid = 4'b0111;
        tick();
        chk_out("x0", 1'b1, 4'd7, 2'd0);
        tick();
        chk_out("x1", 1'b1, 4'd10, 2'd1);
        tick();
        chk_out("x2", 1'b1, 4'd3, 2'd2);
        in_valid = 4'b1000;
        #1;
        chk("x3.ready", 32'(in_ready), 32'b1000);
        tick();
        chk("x3.valid", 32'(out_valid), 32'h1);
        chk("x3.sel", 32'(out_sel), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_mux_4_1_stage.md
Name: rr_mux_4_1_stage

Overview:
- Registered 4-to-1 arbitration and multiplex stage for the 4-input select datapath.
- Four valid/ready request ports compete for one registered valid/ready output.
- Grant is round-robin, so no input starves.
- The granted index drives the 4:1 data select and is also forwarded downstream as out_sel.

Parameters:
WIDTH, 4, data width of every input and of out_data.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  4  in_valid[i]: requester i has a beat on in_data_i
in_data0  input  WIDTH  requester 0 data
in_data1  input  WIDTH  requester 1 data
in_data2  input  WIDTH  requester 2 data
in_data3  input  WIDTH  requester 3 data
in_ready  output  4  in_ready[i]: requester i's beat is accepted this cycle (one-hot or zero)
out_valid  output  1  out_data/out_sel hold a beat
out_data  output  WIDTH  selected data beat
out_sel  output  2  index of the requester that supplied out_data
out_ready  input  1  downstream accepts the beat this cycle

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at posedge): out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0. in_ready=0 while rst=1.
- Handshake rules:
  - Transfer on any port occurs when valid and ready are both 1 at a posedge.
  - Requesters must hold data and valid stable until accepted.
  - Downstream must tolerate out_valid staying high across cycles.
- free = ~out_valid | out_ready. The output register can load this cycle.
- Grant logic (combinational):
  - Scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - g = first index with in_valid set.
  - If none is valid, there is no grant.
- Ready: in_ready[i] = ~rst & free & (grant exists) & (i == g). in_ready is combinationally dependent on out_ready and in_valid, with no combinational path from in_data.
- Register update at posedge, when free:
  - If a grant exists: out_data <= in_data_g, out_sel <= g, out_valid <= 1, ptr <= (g+1) mod 4 (2-bit wrap).
  - If no grant exists: out_valid <= 0. out_data, out_sel and ptr hold.
- When not free (out_valid=1, out_ready=0): all registers hold and in_ready=0. Back-pressure stalls every requester.
- Latency: 1 cycle from accepted input to out_valid. Full throughput is one beat per cycle while out_ready=1.
- Fairness: with all four in_valid held high and out_ready=1, grants rotate 0,1,2,3,0,... Any requester waits at most 3 other grants.
- Simultaneous events:
  - Pop and load in the same cycle is allowed.
  - A newly asserted in_valid[i] may be granted in the same cycle it rises.
- ptr advances only on a granted transfer. Idle cycles do not rotate priority.
- X-handling: in_data of non-granted inputs must not affect out_data. An X on an unselected input never propagates.
- Reset mid-operation: any held beat is discarded (out_valid=0 the next cycle) and ptr returns to 0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000.
- Single requester: in_valid=0100, in_data2=0xC, out_ready=1 -> in_ready=0100 the same cycle. Next cycle out_valid=1, out_data=0xC, out_sel=2. The following grant search starts at 3.
- Round-robin: in_valid=1111 held, in_data0..3 = 0xA,0xB,0xC,0xD, out_ready=1 from reset -> out_data sequence 0xA,0xB,0xC,0xD,0xA with out_sel 0,1,2,3,0.
- Back-pressure: out_valid=1 with out_data=0xB, out_ready=0 for 3 cycles, in_valid=1111 -> in_ready=0000 and out_data stays 0xB for all 3 cycles. When out_ready=1, 0xC loads the next cycle.
- X isolation: in_data0..3 = 7,10,3,X, in_valid=0111, ptr=0 -> outputs 7,10,3 in order and never X. With in_valid=1000, out_data=X and out_sel=3.
- Reset mid-stream: rst=1 while out_valid=1, out_sel=1 -> next cycle out_valid=0. After release with in_valid=1111, the first grant is index 0.
